// File: rtl/cmd_seq_pkg.sv
// cmd_seq_pkg: shared types and constants for the command sequencer.
//   seq_state_t : sequencer FSM states
//   RESP_ACK    : response byte that retires a command successfully
//   RESP_NACK   : canonical negative response (any non-ACK byte is a NACK)
package cmd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_SNT,
        WAIT_RESP
    } seq_state_t;

    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_NACK = 8'h5A;
    localparam int         CMD_W     = 16;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous DEPTH x W command FIFO.
//   clk, rst    : clock, async active-high reset
//   push_i      : write din_i (dropped when full, raising overflow_o)
//   din_i       : data to write
//   pop_i       : retire the head entry (ignored when empty)
//   head_o      : current head entry
//   full_o      : registered, DEPTH entries held
//   empty_o     : registered, no entries held
//   overflow_o  : registered one-cycle pulse for a dropped push
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         overflow_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, empty_q, ovf_q;
    logic          push_ok, pop_ok;

    // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;
    assign cnt_d   = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == (AW+1)'(DEPTH));
            empty_q <= (cnt_d == '0);
            ovf_q   <= push_i && full_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o     = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: queues 16-bit commands and issues them one at a time to
// RemoteComm, waiting for a one-byte response and retrying on NACK/timeout.
//   clk, rst                 : clock, async active-high reset
//   push, push_cmd           : enqueue request
//   full, empty, overflow    : FIFO status (overflow = dropped push pulse)
//   snd_cmd, cmd             : send pulse and command to RemoteComm
//   cmd_snt                  : RemoteComm finished transmitting
//   resp_rx_rdy/_data        : response byte from UART_wrapper
//   resp_clr_rx_rdy          : consumes the response byte
//   busy, done, ok           : FSM active; command retired with status
//   stray                    : response byte arrived outside WAIT_RESP
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int MAX_RETRY   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [CMD_W-1:0] push_cmd,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             snd_cmd,
    output logic [CMD_W-1:0] cmd,
    input  logic             cmd_snt,
    input  logic             resp_rx_rdy,
    input  logic [7:0]       resp_rx_data,
    output logic             resp_clr_rx_rdy,
    output logic             busy,
    output logic             done,
    output logic             ok,
    output logic             stray
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    seq_state_t       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             rx_q, tmo_q;
    logic [7:0]       rx_data_q;
    logic             snd_q, clr_q, done_q, ok_q, stray_q, busy_q;
    logic             snd_d, done_d, ok_d, stray_d;
    logic             pop, rx_cap;
    logic [CMD_W-1:0] head;

    cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .din_i      (push_cmd),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty),
        .overflow_o (overflow)
    );

    // Response and timeout events pass through one register stage so both
    // are judged together; a byte already being consumed is not re-captured
    // while the UART still holds rdy high.
    assign rx_cap = resp_rx_rdy && !rx_q && !clr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_q      <= 1'b0;
            rx_data_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            rx_q  <= rx_cap;
            if (rx_cap) rx_data_q <= resp_rx_data;
            tmo_q <= (state_q == WAIT_RESP) && (timer_q == TMO_LAST) && !tmo_q;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        cmd_d   = cmd_q;
        pop     = 1'b0;
        snd_d   = 1'b0;
        done_d  = 1'b0;
        ok_d    = 1'b0;
        stray_d = rx_q && (state_q != WAIT_RESP);
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = SEND;
                    retry_d = '0;
                    cmd_d   = head;
                end
            end
            SEND: begin
                snd_d   = 1'b1;
                state_d = WAIT_SNT;
            end
            WAIT_SNT: begin
                if (cmd_snt) begin
                    timer_d = '0;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (timer_q != '1) timer_d = timer_q + TW'(1);
                // A response byte takes priority over a coincident timeout.
                if (rx_q && (rx_data_q == RESP_ACK)) begin
                    pop     = 1'b1;
                    done_d  = 1'b1;
                    ok_d    = 1'b1;
                    state_d = IDLE;
                end else if (rx_q || tmo_q) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = SEND;
                    end else begin
                        pop     = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            retry_q <= '0;
            cmd_q   <= '0;
            snd_q   <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            stray_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            cmd_q   <= cmd_d;
            snd_q   <= snd_d;
            clr_q   <= rx_q;
            done_q  <= done_d;
            ok_q    <= ok_d;
            stray_q <= stray_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign snd_cmd         = snd_q;
    assign cmd             = cmd_q;
    assign resp_clr_rx_rdy = clr_q;
    assign done            = done_q;
    assign ok              = ok_q;
    assign stray           = stray_q;
    assign busy            = busy_q;

endmodule
